// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debounce controller: one shared debounce datapath serves NCH
// channels, visiting one channel context per clock in round-robin order.
module debounce_scan_ctrl #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 10,
  localparam int unsigned PW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [NCH-1:0] in,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_rise_len,
  input  logic [CW-1:0]  cfg_fall_len,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] db_tick_rise,
  output logic [NCH-1:0] db_tick_fall,
  output logic [NCH-1:0] busy,
  output logic [PW-1:0]  scan_ptr
);

  typedef enum logic [1:0] {
    StZero  = 2'b00,
    StWait1 = 2'b01,
    StOne   = 2'b10,
    StWait0 = 2'b11
  } st_e;

  localparam logic [CW-1:0] LenRst = CW'(16);

  logic [NCH-1:0] sync1_q, sync2_q, s_in;
  logic [CW-1:0]  rise_len_q, rise_len_d;
  logic [CW-1:0]  fall_len_q, fall_len_d;
  logic [PW-1:0]  scan_ptr_q, scan_ptr_d;
  st_e            st_q  [NCH];
  st_e            st_d  [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] tick_rise_q, tick_rise_d;
  logic [NCH-1:0] tick_fall_q, tick_fall_d;

  // Shared visit datapath signals
  st_e           cur_st, nxt_st;
  logic [CW-1:0] cur_cnt, nxt_cnt, cnt_dec;
  logic          cur_in, hit_rise, hit_fall;

  assign s_in = sync2_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      rise_len_q  <= LenRst;
      fall_len_q  <= LenRst;
      scan_ptr_q  <= '0;
      tick_rise_q <= '0;
      tick_fall_q <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        st_q[c]  <= StZero;
        cnt_q[c] <= '0;
      end
    end else begin
      sync1_q     <= in;
      sync2_q     <= sync1_q;
      rise_len_q  <= rise_len_d;
      fall_len_q  <= fall_len_d;
      scan_ptr_q  <= scan_ptr_d;
      tick_rise_q <= tick_rise_d;
      tick_fall_q <= tick_fall_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        st_q[c]  <= st_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Length registers: a zero length would never qualify, so it is clamped to one
  always_comb begin
    rise_len_d = rise_len_q;
    fall_len_d = fall_len_q;
    if (cfg_we) begin
      rise_len_d = (cfg_rise_len == '0) ? CW'(1) : cfg_rise_len;
      fall_len_d = (cfg_fall_len == '0) ? CW'(1) : cfg_fall_len;
    end
  end

  always_comb begin
    scan_ptr_d = scan_ptr_q;
    if (enable) begin
      scan_ptr_d = (scan_ptr_q == PW'(NCH - 1)) ? '0 : scan_ptr_q + PW'(1);
    end
  end

  // Next-state for the visited channel
  always_comb begin
    cur_st   = st_q[scan_ptr_q];
    cur_cnt  = cnt_q[scan_ptr_q];
    cur_in   = s_in[scan_ptr_q];
    cnt_dec  = cur_cnt - CW'(1);
    nxt_st   = cur_st;
    nxt_cnt  = cur_cnt;
    hit_rise = 1'b0;
    hit_fall = 1'b0;
    case (cur_st)
      StZero: begin
        if (cur_in) begin
          nxt_st  = StWait1;
          nxt_cnt = rise_len_q;
        end
      end
      StWait1: begin
        if (!cur_in) begin
          nxt_st = StZero;
        end else begin
          nxt_cnt = cnt_dec;
          if (cnt_dec == '0) begin
            nxt_st   = StOne;
            hit_rise = 1'b1;
          end
        end
      end
      StOne: begin
        if (!cur_in) begin
          nxt_st  = StWait0;
          nxt_cnt = fall_len_q;
        end
      end
      StWait0: begin
        if (cur_in) begin
          nxt_st = StOne;
        end else begin
          nxt_cnt = cnt_dec;
          if (cnt_dec == '0) begin
            nxt_st   = StZero;
            hit_fall = 1'b1;
          end
        end
      end
      default: nxt_st = StZero;
    endcase
  end

  // Write the visited context back; all other channels hold
  always_comb begin
    tick_rise_d = '0;
    tick_fall_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      st_d[c]  = st_q[c];
      cnt_d[c] = cnt_q[c];
      if (enable && (scan_ptr_q == PW'(c))) begin
        st_d[c]        = nxt_st;
        cnt_d[c]       = nxt_cnt;
        tick_rise_d[c] = hit_rise;
        tick_fall_d[c] = hit_fall;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    db_level = '0;
    busy     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      db_level[c] = (st_q[c] == StOne) || (st_q[c] == StWait0);
      busy[c]     = (st_q[c] == StWait1) || (st_q[c] == StWait0);
    end
  end

  assign db_tick_rise = tick_rise_q;
  assign db_tick_fall = tick_fall_q;
  assign scan_ptr     = scan_ptr_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed stimulus pushes expected ticks with their
// clock stamps into a queue; a negedge monitor pops and compares each observed tick.
module tb_debounce_scan_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [NCH-1:0] in_r;
  logic           cfg_we;
  logic [CW-1:0]  cfg_rise_len, cfg_fall_len;
  logic [NCH-1:0] db_level, db_tick_rise, db_tick_fall, busy;
  logic [1:0]     scan_ptr;

  debounce_scan_ctrl #(.NCH(NCH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in           (in_r),
    .cfg_we       (cfg_we),
    .cfg_rise_len (cfg_rise_len),
    .cfg_fall_len (cfg_fall_len),
    .db_level     (db_level),
    .db_tick_rise (db_tick_rise),
    .db_tick_fall (db_tick_fall),
    .busy         (busy),
    .scan_ptr     (scan_ptr)
  );

  always #4 clk = ~clk;

  typedef struct {
    bit rise;
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align(input int p);
    int guard = 0;
    while (scan_ptr != p[1:0] && guard < 8) begin
      step(1);
      guard++;
    end
    check("align_scan_ptr", {30'd0, scan_ptr}, p);
  endtask

  task automatic push(input bit r, input int ch, input int c);
    exp_t e;
    e.rise = r;
    e.ch   = ch;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input int r, input int f);
    cfg_we       = 1'b1;
    cfg_rise_len = r[CW-1:0];
    cfg_fall_len = f[CW-1:0];
    step(1);
    cfg_we       = 1'b0;
  endtask

  // Monitor: every tick must match the oldest outstanding expectation exactly
  logic [NCH-1:0] t_all;
  int             t_ch;
  exp_t           t_e;
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      t_e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missed_tick: ch %0d rise %0d expected at cyc %0d, not seen",
               t_e.ch, t_e.rise, t_e.cyc);
    end
    t_all = db_tick_rise | db_tick_fall;
    if (t_all != '0) begin
      n_cmp++;
      t_ch = 0;
      for (int i = 0; i < NCH; i++) if (t_all[i]) t_ch = i;
      if ($countones(t_all) != 1 || (db_tick_rise != '0 && db_tick_fall != '0)) begin
        n_err++;
        $display("FAIL tick_onehot: rise %b fall %b, required a single bit (cyc %0d)",
                 db_tick_rise, db_tick_fall, cyc);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tick: rise %b fall %b at cyc %0d, none expected",
                 db_tick_rise, db_tick_fall, cyc);
      end else begin
        t_e = exp_q.pop_front();
        if (t_e.rise != (db_tick_rise != '0) || t_e.ch != t_ch || t_e.cyc != cyc) begin
          n_err++;
          $display("FAIL tick: got ch %0d rise %0d cyc %0d, expected ch %0d rise %0d cyc %0d",
                   t_ch, (db_tick_rise != '0), cyc, t_e.ch, t_e.rise, t_e.cyc);
        end
      end
    end
  end

  int k, r;

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    in_r         = '0;
    cfg_we       = 1'b0;
    cfg_rise_len = '0;
    cfg_fall_len = '0;
    step(3);
    check("rst_level", db_level, 0);
    check("rst_busy", busy, 0);
    check("rst_ticks", {db_tick_rise, db_tick_fall}, 0);
    check("rst_ptr", scan_ptr, 0);
    reset = 1'b0;
    step(2);

    // Clean rise on ch0, rise_len 3: tick 12 clk after the detecting visit
    cfg(3, 3);
    step(4);
    align(2);
    k = cyc;
    in_r[0] = 1'b1;
    push(1, 0, k + 15);
    step(14);
    check("rise_before", db_level, 4'b0000);
    step(1);
    check("rise_level", db_level, 4'b0001);
    step(5);

    // Short high on ch1 is rejected
    align(3);
    in_r[1] = 1'b1;
    step(6);
    in_r[1] = 1'b0;
    step(30);
    check("glitch_level", db_level, 4'b0001);
    check("glitch_busy", busy, 4'b0000);

    // One-visit dropout on ch0 returns to ONE without a fall tick
    align(2);
    in_r[0] = 1'b0;
    step(4);
    check("dropout_busy", busy, 4'b0001);
    in_r[0] = 1'b1;
    step(30);
    check("dropout_level", db_level, 4'b0001);
    check("dropout_idle", busy, 4'b0000);

    // Fall on ch0 with fall_len 3
    align(2);
    k = cyc;
    in_r[0] = 1'b0;
    push(0, 0, k + 15);
    step(24);
    check("fall0_level", db_level, 4'b0000);

    // Simultaneous rise, rise_len 2: ticks on consecutive clocks in scan order
    cfg(2, 3);
    step(2);
    align(2);
    k = cyc;
    in_r = 4'b1111;
    push(1, 0, k + 11);
    push(1, 1, k + 12);
    push(1, 2, k + 13);
    push(1, 3, k + 14);
    step(20);
    check("simul_level", db_level, 4'b1111);

    // fall_len 0 is stored as 1: ch2 falls one visit after detection
    cfg(2, 0);
    step(2);
    align(0);
    k = cyc;
    in_r[2] = 1'b0;
    push(0, 2, k + 7);
    step(12);
    check("clamp_level", db_level, 4'b1011);

    // Mid-count reconfiguration and enable freeze on ch3
    align(1);
    k = cyc;
    in_r[3] = 1'b0;
    push(0, 3, k + 7);
    step(12);
    check("fall3_level", db_level, 4'b0011);
    cfg(8, 1);
    step(2);
    align(1);
    k = cyc;
    in_r[3] = 1'b1;
    while (cyc < k + 16) step(1);
    cfg(2, 1);
    enable = 1'b0;
    step(10);
    check("frozen_busy", busy, 4'b1000);
    check("frozen_level", db_level, 4'b0011);
    check("frozen_ptr", scan_ptr, 2);
    step(10);
    enable = 1'b1;
    push(1, 3, k + 55);
    step(25);
    check("resume_level", db_level, 4'b1011);

    // Reset with ch0 in ONE and ch1 in WAIT1
    align(3);
    k = cyc;
    in_r[1] = 1'b0;
    push(0, 1, k + 7);
    step(12);
    check("fall1_level", db_level, 4'b1001);
    align(3);
    in_r[1] = 1'b1;
    step(6);
    check("pre_reset_busy", busy, 4'b0010);
    reset = 1'b1;
    in_r  = 4'b1111;
    #1;
    check("reset_level", db_level, 0);
    check("reset_busy", busy, 0);
    check("reset_ticks", {db_tick_rise, db_tick_fall}, 0);
    check("reset_ptr", scan_ptr, 0);
    step(3);
    reset = 1'b0;
    r = cyc;
    push(1, 2, r + 67);
    push(1, 3, r + 68);
    push(1, 0, r + 69);
    push(1, 1, r + 70);
    step(64);
    check("requal_before", db_level, 4'b0000);
    step(10);
    check("requal_level", db_level, 4'b1111);

    step(2);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
